// File: rtl/f5_vector_checker.sv
// Truth-table vector checker: compares two implementations against a minterm mask.
// Optional define CHECK_ORDER_EN enforces ascending row order.
module f5_vector_checker #(
   parameter int N_IN = 2,
   parameter logic [(1<<N_IN)-1:0] MINTERMS = 4'b0010,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_IN-1:0]        in_vec,
   input  logic                   out_a,
   input  logic                   out_b,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   mismatch,
   output logic [CNT_W-1:0]       err_count,
   output logic [(1<<N_IN)-1:0]   seen_mask
);
   localparam int ROWS = 1 << N_IN;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q;
   state_t          state_d;
   logic            beat;
   logic            clr;
   logic            exp_val;
   logic            in_order;
   logic            fail;
   logic            full;
   logic [ROWS-1:0] row_bit;
   logic [ROWS-1:0] seen_d;

`ifdef CHECK_ORDER_EN
   logic [N_IN-1:0] next_row;
   assign in_order = (in_vec == next_row);
`else
   assign in_order = 1'b1;
`endif

   assign in_ready = (state_q == RUN);
   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign pass     = done && (err_count == '0);

   assign beat    = in_valid && in_ready;
   assign clr     = start && (state_q != RUN);
   assign exp_val = MINTERMS[in_vec];
   assign fail    = (out_a != exp_val) || (out_b != exp_val) || !in_order;
   assign row_bit = ROWS'(1) << in_vec;
   // Out-of-order rows leave coverage untouched
   assign seen_d  = in_order ? (seen_mask | row_bit) : seen_mask;
   assign full    = &seen_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN:  if (beat && full) state_d = DONE;
         DONE: if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mismatch  <= 1'b0;
         err_count <= '0;
         seen_mask <= '0;
`ifdef CHECK_ORDER_EN
         next_row  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         mismatch <= beat && fail;
         if (clr) begin
            err_count <= '0;
            seen_mask <= '0;
`ifdef CHECK_ORDER_EN
            next_row  <= '0;
`endif
         end else if (beat) begin
            if (fail && (err_count != '1))
               err_count <= err_count + CNT_W'(1);
            seen_mask <= seen_d;
`ifdef CHECK_ORDER_EN
            if (in_order)
               next_row <= next_row + N_IN'(1);
`endif
         end
      end
   end

endmodule

// File: tb/tb_f5_vector_checker.sv
// Scoreboard bench for f5_vector_checker: default build plus a CNT_W=2 twin.
// Expected results come from a row-set model of the function a'.b.
module tb_f5_vector_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       in_valid;
   logic [1:0] in_vec;
   logic       out_a;
   logic       out_b;

   logic       in_ready, busy, done, pass, mismatch;
   logic [7:0] err_count;
   logic [3:0] seen_mask;

   logic       s_in_ready, s_busy, s_done, s_pass, s_mismatch;
   logic [1:0] s_err_count;
   logic [3:0] s_seen_mask;

   f5_vector_checker dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .in_vec(in_vec), .out_a(out_a), .out_b(out_b),
      .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
      .err_count(err_count), .seen_mask(seen_mask)
   );

   f5_vector_checker #(.CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(s_in_ready), .in_vec(in_vec), .out_a(out_a), .out_b(out_b),
      .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mismatch),
      .err_count(s_err_count), .seen_mask(s_seen_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mism;
      int err8;
      int err2;
      int seen;
      int dn;
      int ps;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   // reference model state
   bit   running = 0;
   int   errs = 0;
   bit   seen[4];
   int   next_row = 0;

   task automatic check(string name, int act, int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic bit f(int m);
      bit x, y;
      x = ((m >> 1) & 1) != 0;
      y = (m & 1) != 0;
      return !x && y;
   endfunction

   function automatic bit nand_f(int m);
      bit x, y;
      x = ((m >> 1) & 1) != 0;
      y = (m & 1) != 0;
      return !x || !y;
   endfunction

   function automatic int seen_bits();
      int s = 0;
      for (int i = 0; i < 4; i++) if (seen[i]) s += (1 << i);
      return s;
   endfunction

   task automatic model_clear();
      errs = 0;
      next_row = 0;
      for (int i = 0; i < 4; i++) seen[i] = 0;
   endtask

   task automatic beat(int row, bit a, bit b);
      bit   ordered, bad, cov;
      exp_t e;
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_vec   = row[1:0];
      out_a    = a;
      out_b    = b;
      if (running) begin
         ordered = 1;
`ifdef CHECK_ORDER_EN
         ordered = (row == next_row);
`endif
         bad = (a != f(row)) || (b != f(row)) || !ordered;
         if (bad) errs++;
         if (ordered) begin
            seen[row] = 1;
            next_row++;
         end
         cov = seen[0] && seen[1] && seen[2] && seen[3];
         if (cov) running = 0;
         e.mism = bad;
         e.err8 = (errs > 255) ? 255 : errs;
         e.err2 = (errs > 3) ? 3 : errs;
         e.seen = seen_bits();
         e.dn   = cov;
         e.ps   = cov && (errs == 0);
         q.push_back(e);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic do_start();
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      running = 1;
      model_clear();
      @(negedge clk);
      check("start_busy", busy, 1);
      check("start_ready", in_ready, 1);
      check("start_done", done, 0);
      check("start_err", err_count, 0);
      check("start_seen", seen_mask, 0);
      check("start_s_err", s_err_count, 0);
      check("start_s_busy", s_busy, 1);
   endtask

   task automatic finish_run();
      int n = 0;
      int row;
      while (running && n < 20) begin
         row = 0;
`ifdef CHECK_ORDER_EN
         row = next_row;
`else
         while (seen[row]) row++;
`endif
         beat(row, f(row), f(row));
         n++;
      end
      if (running) begin
         n_tot++;
         $display("FAIL finish_bound: got running=1 expected running=0");
         running = 0;
      end
      idle();
   endtask

   task automatic check_zero(string tag);
      check({tag, "_ready"}, in_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_mism"}, mismatch, 0);
      check({tag, "_err"}, err_count, 0);
      check({tag, "_seen"}, seen_mask, 0);
      check({tag, "_s_err"}, s_err_count, 0);
      check({tag, "_s_mism"}, s_mismatch, 0);
   endtask

   // monitor: a beat sampled before an edge is checked after that edge
   initial begin
      bit   fire = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (fire) begin
               if (q.size() == 0) begin
                  n_tot++;
                  $display("FAIL unexpected_beat: got accept expected none");
               end else begin
                  e = q.pop_front();
                  check("mismatch", mismatch, e.mism);
                  check("err_count", err_count, e.err8);
                  check("s_err_count", s_err_count, e.err2);
                  check("seen_mask", seen_mask, e.seen);
                  check("s_seen_mask", s_seen_mask, e.seen);
                  check("done", done, e.dn);
                  check("busy", busy, e.dn ? 0 : 1);
                  check("in_ready", in_ready, e.dn ? 0 : 1);
                  check("pass", pass, e.ps);
                  check("s_pass", s_pass, e.ps);
                  check("s_mismatch", s_mismatch, e.mism);
               end
            end else begin
               check("mismatch_idle", mismatch, 0);
            end
         end
         fire = (rst_n === 1'b1) && in_valid && in_ready;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int row, n;
      bit a, b;
      int rows4[5] = '{1, 1, 0, 2, 3};
      rst_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      in_vec = 2'd0;
      out_a = 1'b0;
      out_b = 1'b0;
      #3;
      check_zero("reset");
      #10;
      rst_n = 1'b1;

      // beats in IDLE are ignored
      beat(1, 1, 1);
      beat(2, 1, 0);
      idle();

      // clean run
      do_start();
      for (int r = 0; r < 4; r++) beat(r, f(r), f(r));
      finish_run();

      // implementation B computes a nand
      do_start();
      for (int r = 0; r < 4; r++) beat(r, f(r), nand_f(r));
      finish_run();

      // duplicates
      do_start();
      for (int i = 0; i < 5; i++) beat(rows4[i], f(rows4[i]), f(rows4[i]));
      finish_run();

      // valid held in DONE
      repeat (4) beat(0, 1, 1);
      idle();
      check("hold_done", done, 1);

      // asynchronous reset mid-run
      do_start();
      beat(0, 1, 1);
      beat(3, 0, 0);
      idle();
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      running = 0;
      model_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
      beat(2, 0, 0);
      idle();

      // all failing beats: narrow counter saturates
      do_start();
      n = 0;
      while (running && n < 200) begin
         row = $urandom_range(0, 3);
         beat(row, !f(row), !f(row));
         n++;
      end
      finish_run();

      // wide counter saturation via duplicates
      do_start();
      repeat (300) beat(0, !f(0), f(0));
      finish_run();

      // random runs
      repeat (10) begin
         do_start();
         n = 0;
         while (running && n < 200) begin
            if ($urandom_range(0, 3) == 0) idle();
            row = $urandom_range(0, 3);
            a = f(row) ^ ($urandom_range(0, 7) == 0);
            b = f(row) ^ ($urandom_range(0, 7) == 0);
            beat(row, a, b);
            n++;
         end
         finish_run();
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("queue_drain", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
